// File: rtl/dense_mac_unit.sv
// Dense-layer dot-product engine: 3-lane signed Q8.8 MAC over a row of beats,
// then clamp/activation. Optional saturation on narrowing: define DENSE_MAC_SAT_EN.
module dense_mac_unit #(
  parameter int LANES      = 3,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        start,
  input  logic [3:0]                  act_type,
  input  logic [LANES*DATA_WIDTH-1:0] weight_data,
  input  logic [LANES*DATA_WIDTH-1:0] input_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        overflow
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   drain_cnt, drain_cnt_nxt;
  logic   acc_clr, beat_acc, load_out;
  logic [3:0] act_q;

  logic signed [DATA_WIDTH-1:0] w_lane [LANES];
  logic signed [DATA_WIDTH-1:0] x_lane [LANES];
  logic signed [PROD_W-1:0]     prod_p1 [LANES];
  logic                         vld_p1;
  logic signed [ACC_WIDTH-1:0]  beat_sum;
  logic signed [ACC_WIDTH-1:0]  acc_p2;
  logic [DATA_WIDTH-1:0]        out_data_p3;
  logic                         ovf_p3;

  function automatic logic out_of_range(input logic signed [ACC_WIDTH-1:0] a);
    return (a > OUT_MAX) || (a < OUT_MIN);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] narrow(
    input logic signed [ACC_WIDTH-1:0] a
  );
`ifdef DENSE_MAC_SAT_EN
    if (a > OUT_MAX) return OUT_MAX[DATA_WIDTH-1:0];
    if (a < OUT_MIN) return OUT_MIN[DATA_WIDTH-1:0];
    return a[DATA_WIDTH-1:0];
`else
    return a[DATA_WIDTH-1:0];
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] activate(
    input logic [3:0]                   act,
    input logic signed [DATA_WIDTH-1:0] v
  );
    case (act)
      4'd1:    return v[DATA_WIDTH-1] ? '0 : v;
      4'd2:    return v[DATA_WIDTH-1] ? (v >>> 3) : v;
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    in_ready      = 1'b0;
    acc_clr       = 1'b0;
    beat_acc      = 1'b0;
    load_out      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ACC;
          acc_clr   = 1'b1;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_acc = 1'b1;
          if (in_last) begin
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Two cycles let the last beat clear the product and accumulate stages.
        if (drain_cnt) begin
          drain_cnt_nxt = 1'b0;
        end else begin
          state_nxt = S_OUT;
          load_out  = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      act_q     <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (acc_clr) act_q <= act_type;
    end
  end

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign out_data  = out_data_p3;
  assign overflow  = ovf_p3;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane[i] = weight_data[i*DATA_WIDTH +: DATA_WIDTH];
      x_lane[i] = input_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage 1: per-lane signed products
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_p1[i] <= '0;
    end else begin
      vld_p1 <= beat_acc;
      if (beat_acc) begin
        for (int i = 0; i < LANES; i++)
          prod_p1[i] <= PROD_W'(w_lane[i]) * PROD_W'(x_lane[i]);
      end
    end
  end

  // Lane sum is formed at accumulator width so three full-scale products cannot wrap.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++)
      beat_sum = beat_sum +
        {{(ACC_WIDTH-PROD_W){prod_p1[i][PROD_W-1]}}, prod_p1[i]};
  end

  // Stage 2: accumulate Q8.8-rescaled beat sum
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc_p2 <= '0;
    end else if (acc_clr) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= acc_p2 + (beat_sum >>> FRAC_BITS);
    end
  end

  // Stage 3: narrow, activate and hold for the consumer
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_data_p3 <= '0;
      ovf_p3      <= 1'b0;
    end else if (load_out) begin
      out_data_p3 <= activate(act_q, narrow(acc_p2));
      ovf_p3      <= out_of_range(acc_p2);
    end
  end

endmodule

// File: tb/tb_dense_mac_unit.sv
// Directed bench for dense_mac_unit: latency, activations, overflow,
// backpressure and mid-row reset, with immediate-assertion checks.
module tb_dense_mac_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  act_type;
  logic [47:0] weight_data;
  logic [47:0] input_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  dense_mac_unit dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start         (start),
    .act_type      (act_type),
    .weight_data   (weight_data),
    .input_data    (input_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] act);
    start    = 1'b1;
    act_type = act;
    tick();
    start    = 1'b0;
  endtask

  task automatic beat(input logic [47:0] w, input logic [47:0] x, input logic last);
    weight_data = w;
    input_data  = x;
    in_valid    = 1'b1;
    in_last     = last;
    tick();
    in_valid    = 1'b0;
    in_last     = 1'b0;
  endtask

  // After the last beat's edge, two DRAIN cycles pass before out_valid.
  task automatic wait_result(input string tag);
    chk({tag, "_ready_lo"}, in_ready, 0);
    chk({tag, "_vld_t1"}, out_valid, 0);
    tick();
    chk({tag, "_vld_t2"}, out_valid, 0);
    tick();
    chk({tag, "_vld_t3"}, out_valid, 1);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_vld"}, out_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  logic [15:0] sat_exp;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    act_type    = 4'd0;
    weight_data = '0;
    input_data  = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // single beat: 0.5 + 1.0 + 2.0 = 3.5
    do_start(4'd0);
    chk("s1_busy", busy, 1);
    chk("s1_in_ready", in_ready, 1);
    beat(48'h0100_0100_0100, 48'h0080_0100_0200, 1'b1);
    wait_result("s1");
    chk("s1_data", out_data, 16'h0380);
    chk("s1_ovf", overflow, 0);
    pop("s1");

    // two beats of 3.0 each
    do_start(4'd0);
    beat(48'h0100_0100_0100, 48'h0100_0100_0100, 1'b0);
    chk("s2_mid_ready", in_ready, 1);
    beat(48'h0100_0100_0100, 48'h0100_0100_0100, 1'b1);
    wait_result("s2");
    chk("s2_data", out_data, 16'h0600);
    chk("s2_ovf", overflow, 0);
    pop("s2");
    chk("s2_idle_ready", in_ready, 0);

    // -1.0 through identity, ReLU, leaky ReLU and an unused selector
    do_start(4'd0);
    beat(48'h0000_0000_0100, 48'h0000_0000_FF00, 1'b1);
    wait_result("id");
    chk("id_data", out_data, 16'hFF00);
    pop("id");

    do_start(4'd1);
    beat(48'h0000_0000_0100, 48'h0000_0000_FF00, 1'b1);
    wait_result("relu");
    chk("relu_data", out_data, 16'h0000);
    chk("relu_ovf", overflow, 0);
    pop("relu");

    do_start(4'd2);
    beat(48'h0000_0000_0100, 48'h0000_0000_FF00, 1'b1);
    wait_result("leaky");
    chk("leaky_data", out_data, 16'hFFE0);
    pop("leaky");

    do_start(4'd9);
    beat(48'h0000_0000_0100, 48'h0000_0000_FF00, 1'b1);
    wait_result("act9");
    chk("act9_data", out_data, 16'hFF00);
    pop("act9");

    // ReLU passes a positive value unchanged
    do_start(4'd1);
    beat(48'h0100_0100_0100, 48'h0080_0100_0200, 1'b1);
    wait_result("relu_pos");
    chk("relu_pos_data", out_data, 16'h0380);
    pop("relu_pos");

    // three full-scale beats: acc = 3 * 0xBFFD00 = 0x23FF700
`ifdef DENSE_MAC_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hF700;
`endif
    do_start(4'd0);
    beat({3{16'h7FFF}}, {3{16'h7FFF}}, 1'b0);
    beat({3{16'h7FFF}}, {3{16'h7FFF}}, 1'b0);
    beat({3{16'h7FFF}}, {3{16'h7FFF}}, 1'b1);
    wait_result("sat");
    chk("sat_data", out_data, {16'h0, sat_exp});
    chk("sat_ovf", overflow, 1);

    // backpressure: hold 5 cycles with start pulses that must be ignored
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
      chk("bp_vld", out_valid, 1);
      chk("bp_data", out_data, {16'h0, sat_exp});
      chk("bp_ovf", overflow, 1);
    end
    start = 1'b0;
    pop("bp");
    chk("bp_ovf_hold_after", overflow, 1);

    // start with a beat in the same IDLE cycle: the beat is not taken
    start       = 1'b1;
    act_type    = 4'd0;
    weight_data = {3{16'h7FFF}};
    input_data  = {3{16'h7FFF}};
    in_valid    = 1'b1;
    in_last     = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("sv_busy", busy, 1);
    chk("sv_still_acc", in_ready, 1);
    beat(48'h0100_0100_0100, 48'h0080_0100_0200, 1'b1);
    wait_result("sv");
    chk("sv_data", out_data, 16'h0380);
    chk("sv_ovf", overflow, 0);
    pop("sv");

    // async reset mid-row, then a clean row
    do_start(4'd2);
    beat({3{16'h7FFF}}, {3{16'h7FFF}}, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_overflow", overflow, 0);
    chk("mr_out_data", out_data, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mr_idle", busy, 0);
    do_start(4'd0);
    beat(48'h0100_0100_0100, 48'h0080_0100_0200, 1'b1);
    wait_result("mr");
    chk("mr_data", out_data, 16'h0380);
    chk("mr_ovf", overflow, 0);
    pop("mr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dense_mac_unit.md
Name: dense_mac_unit

Overview:
- Dense-layer dot-product engine directly downstream of data_path.
- Consumes the 48-bit weight-storage and input-storage read words. Each word is 3 lanes of signed Q8.8.
- Accumulates lane products over a row of beats, then applies the activation selected by the parser's act_type.
- Returns one 16-bit neuron output (z) per row to the controller through a valid/ready handshake.

Parameters:
- LANES, 3, 16-bit lanes per 48-bit word.
- DATA_WIDTH, 16, lane width, signed fixed point.
- FRAC_BITS, 8, fractional bits of every lane and of the output.
- ACC_WIDTH, 40, internal accumulator width, signed.

Ports:
- clk_clk  in  1  system clock, rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin new row; clears accumulator; honoured only in IDLE.
- act_type  in  4  activation select, sampled on accepted start.
- weight_data  in  48  lanes {w2,w1,w0}; w2 = bits 47:32.
- input_data  in  48  lanes {x2,x1,x0}, same packing.
- in_valid  in  1  weight_data/input_data beat valid.
- in_last  in  1  marks final beat of row; qualified by in_valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- out_data  out  16  activated neuron output, Q8.8.
- out_valid  out  1  out_data valid; held until out_ready.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  row result exceeded 16-bit range; valid with out_valid.

Behaviour:
- Reset (async, any state, including mid-row): state=IDLE, accumulator=0, pipeline registers=0. All outputs 0: in_ready, out_valid, busy, overflow, out_data.
- State machine:
  - IDLE --start--> ACC. Accumulator cleared; act_type latched.
  - ACC: in_ready=1. Each accepted beat enters the product stage. Accepted beat with in_last=1 --> DRAIN.
  - DRAIN: in_ready=0. Two cycles (counter 1..0) flush the pipeline, then --> OUT.
  - OUT: out_valid=1. out_valid & out_ready --> IDLE.
- start in ACC, DRAIN or OUT is ignored. start in IDLE with in_valid high the same cycle: the beat is not accepted (in_ready=0 in IDLE).
- Pipeline for each accepted beat:
  - Stage 1: three signed 32-bit products p_i = w_i*x_i, registered.
  - Stage 2: acc += (p0+p1+p2) >>> FRAC_BITS (arithmetic shift, truncation toward -inf), sign-extended to ACC_WIDTH.
- Latency: last beat accepted at cycle T -> accumulator final at T+2 -> out_data/out_valid registered at T+3.
- Output conversion:
  - acc clamped to [-32768, 32767] (see optional feature). overflow=1 if acc was outside that range.
  - Activation: 0 identity; 1 ReLU (negative -> 0); 2 leaky ReLU (negative -> value >>> 3); 3..15 identity.
- Activation is applied after the clamp.
- out_data and overflow stay stable while out_valid=1 and out_ready=0.
- A zero-beat row is impossible: in_last is only seen on an accepted beat.
- Accumulator wraps silently at ACC_WIDTH. Rows longer than 2^(ACC_WIDTH-32) beats are unsupported.

Optional Feature:
- Macro DENSE_MAC_SAT_EN.
- Defined: clamp on conversion to 16 bits as described; overflow reflects clamping.
- Undefined: out_data = acc[15:0] (wrap-around). overflow still computed and reported, but no clamping.

Test Plan:
- Single beat: start, act_type=0, w={0x0100,0x0100,0x0100}, x={0x0080,0x0100,0x0200}, in_last=1 -> out_data=0x0380 at T+3, overflow=0.
- Two beats: all w=0x0100, x lanes 0x0100 both beats, act_type=0 -> out_data=0x0600. in_ready low from the cycle after the last beat until the next start.
- ReLU/leaky: one beat, w={0x0100,0,0}, x={0xFF00,0,0} (-1.0). act_type=1 -> 0x0000; act_type=2 -> 0xFFE0.
- Saturation: three beats, all lanes w=x=0x7FFF, act_type=0 -> out_data=0x7FFF, overflow=1 with DENSE_MAC_SAT_EN. Without it: low 16 bits of acc, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable. start pulses during that window ignored. IDLE one cycle after out_ready=1.
- Reset mid-row: deassert reset_reset_n during ACC after one beat -> all outputs 0 immediately. After release, a new 1-beat row gives a result free of the stale beat (0x0380 case repeats exactly).
